// File: rtl/duck_pkg.sv
// Shared types, defaults and distance helpers for the duck-hunt shot path.
// The hit test and the flash overlay both go through in_box so they can never disagree.
package duck_pkg;

   typedef enum logic [2:0] {
      ST_EMPTY    = 3'd0,
      ST_READY    = 3'd1,
      ST_FLASH    = 3'd2,
      ST_JUDGE    = 3'd3,
      ST_COOLDOWN = 3'd4
   } shot_state_t;

   localparam logic [7:0]  FIRE_KEY_DEFAULT = 8'h2C;
   localparam int unsigned SCREEN_W         = 640;
   localparam int unsigned SCREEN_H         = 480;

   // Magnitude of a-b using an 11-bit signed difference, so nothing wraps near 0 or the right edge.
   function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[10]) begin
         abs_diff10 = 10'(11'd0 - d);
      end else begin
         abs_diff10 = d[9:0];
      end
   endfunction

   function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] cx, input logic [9:0] cy,
                                   input logic [9:0] radius);
      return (abs_diff10(px, cx) <= radius) && (abs_diff10(py, cy) <= radius);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame_clk into the Clk domain and emits a registered
// one-cycle tick per rising edge, three Clk cycles after the rise.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic tick
);

   logic sync1_r;
   logic sync2_r;
   logic sync3_r;
   logic tick_r;

   // Two-flop synchroniser, an edge-history flop and the registered edge detect.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
         tick_r  <= 1'b0;
      end else begin
         sync1_r <= frame_clk;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         tick_r  <= sync2_r & ~sync3_r;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/shot_controller.sv
// Per-shot sequencer: fire edge, flash frames, one-cycle hit judgement, cooldown,
// with per-round shot accounting and one-cycle hit/miss events.
module shot_controller
   import duck_pkg::*;
#(
   parameter logic [7:0]  FIRE_KEY        = FIRE_KEY_DEFAULT,
   parameter int unsigned SHOTS_PER_ROUND = 3,
   parameter int unsigned FLASH_FRAMES    = 2,
   parameter int unsigned COOLDOWN_FRAMES = 12,
   parameter int unsigned HIT_RADIUS      = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       round_start,
   input  logic [9:0] cursor_x,
   input  logic [9:0] cursor_y,
   input  logic [9:0] duck_x,
   input  logic [9:0] duck_y,
   input  logic       duck_alive,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic       cursor_freeze,
   output logic       flash_active,
   output logic       flash_white,
   output logic [1:0] shots_left,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] S_EMPTY    = ST_EMPTY;
   localparam logic [2:0] S_READY    = ST_READY;
   localparam logic [2:0] S_FLASH    = ST_FLASH;
   localparam logic [2:0] S_JUDGE    = ST_JUDGE;
   localparam logic [2:0] S_COOLDOWN = ST_COOLDOWN;

   localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
   localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN_FRAMES);
   localparam logic [1:0] SHOT_LOAD  = 2'(SHOTS_PER_ROUND);
   localparam logic [9:0] RADIUS     = 10'(HIT_RADIUS);

   logic       tick_s;
   logic       key_down_s;
   logic       fire_prev_r;
   logic       fire_s;
   logic       hit_s;

   logic [2:0] state_r,  state_n;
   logic [1:0] shots_r,  shots_n;
   logic [7:0] cnt_r,    cnt_n;
   logic [9:0] shot_x_r, shot_x_n;
   logic [9:0] shot_y_r, shot_y_n;
   logic       hit_r,    hit_n;
   logic       miss_r,   miss_n;
   logic       flash_r;
   logic       freeze_r;

   frame_tick_gen u_tick (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .tick      (tick_s)
   );

   assign key_down_s = (keycode == FIRE_KEY);
   assign fire_s     = key_down_s & ~fire_prev_r;
   assign hit_s      = duck_alive & in_box(shot_x_r, shot_y_r, duck_x, duck_y, RADIUS);

   // Next-state logic; round_start overrides everything and silently aborts any shot in flight.
   always_comb begin
      state_n  = state_r;
      shots_n  = shots_r;
      cnt_n    = cnt_r;
      shot_x_n = shot_x_r;
      shot_y_n = shot_y_r;
      hit_n    = 1'b0;
      miss_n   = 1'b0;
      if (round_start) begin
         state_n = S_READY;
         shots_n = SHOT_LOAD;
         cnt_n   = 8'd0;
      end else begin
         case (state_r)
            S_EMPTY: begin
               state_n = S_EMPTY;
            end
            S_READY: begin
               if (shots_r == 2'd0) begin
                  state_n = S_EMPTY;
               end else if (fire_s) begin
                  state_n  = S_FLASH;
                  shots_n  = shots_r - 2'd1;
                  cnt_n    = FLASH_LOAD;
                  shot_x_n = cursor_x;
                  shot_y_n = cursor_y;
               end else begin
                  state_n = S_READY;
               end
            end
            S_FLASH: begin
               if (tick_s && (cnt_r <= 8'd1)) begin
                  state_n = S_JUDGE;
                  cnt_n   = 8'd0;
               end else if (tick_s) begin
                  cnt_n = cnt_r - 8'd1;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            S_JUDGE: begin
               hit_n   = hit_s;
               miss_n  = ~hit_s;
               state_n = S_COOLDOWN;
               cnt_n   = COOL_LOAD;
            end
            S_COOLDOWN: begin
               if (tick_s && (cnt_r <= 8'd1)) begin
                  cnt_n = 8'd0;
                  if (shots_r != 2'd0) begin
                     state_n = S_READY;
                  end else begin
                     state_n = S_EMPTY;
                  end
               end else if (tick_s) begin
                  cnt_n = cnt_r - 8'd1;
               end else begin
                  cnt_n = cnt_r;
               end
            end
            default: begin
               state_n = S_EMPTY;
               cnt_n   = 8'd0;
            end
         endcase
      end
   end

   // State, counters and registered outputs; flags are decoded from the next state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= S_EMPTY;
         shots_r     <= 2'd0;
         cnt_r       <= 8'd0;
         shot_x_r    <= 10'd0;
         shot_y_r    <= 10'd0;
         hit_r       <= 1'b0;
         miss_r      <= 1'b0;
         flash_r     <= 1'b0;
         freeze_r    <= 1'b0;
         fire_prev_r <= 1'b0;
      end else begin
         state_r     <= state_n;
         shots_r     <= shots_n;
         cnt_r       <= cnt_n;
         shot_x_r    <= shot_x_n;
         shot_y_r    <= shot_y_n;
         hit_r       <= hit_n;
         miss_r      <= miss_n;
         flash_r     <= (state_n == S_FLASH);
         freeze_r    <= (state_n == S_FLASH) || (state_n == S_JUDGE);
         fire_prev_r <= key_down_s;
      end
   end

   assign flash_white   = flash_r & in_box(DrawX, DrawY, duck_x, duck_y, RADIUS);
   assign cursor_freeze = freeze_r;
   assign flash_active  = flash_r;
   assign shots_left    = shots_r;
   assign hit_pulse     = hit_r;
   assign miss_pulse    = miss_r;
   assign state_dbg     = state_r;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller; a scoreboard queue holds the expected
// hit/miss outcome of each shot and is drained as the pulses appear.
module tb_shot_controller;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       round_start = 1'b0;
   logic [9:0] cursor_x = 10'd0, cursor_y = 10'd0;
   logic [9:0] duck_x = 10'd0, duck_y = 10'd0;
   logic       duck_alive = 1'b0;
   logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
   logic       cursor_freeze, flash_active, flash_white;
   logic [1:0] shots_left;
   logic       hit_pulse, miss_pulse;
   logic [2:0] state_dbg;

   localparam logic [7:0] KEY = 8'h2C;
   localparam logic [2:0] EMPTY = 3'd0, READY = 3'd1, FLASH = 3'd2, JUDGE = 3'd3, COOL = 3'd4;

   int   n_cmp = 0;
   int   n_err = 0;
   logic sb[$];

   shot_controller dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .round_start(round_start), .cursor_x(cursor_x), .cursor_y(cursor_y),
      .duck_x(duck_x), .duck_y(duck_y), .duck_alive(duck_alive),
      .DrawX(DrawX), .DrawY(DrawY), .cursor_freeze(cursor_freeze),
      .flash_active(flash_active), .flash_white(flash_white), .shots_left(shots_left),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .state_dbg(state_dbg)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // One frame: low long enough to re-arm the synchroniser, then high until the tick is consumed.
   task automatic frame();
      frame_clk = 1'b0;
      step(4);
      frame_clk = 1'b1;
      step(4);
   endtask

   // Every hit/miss pulse must match the next queued outcome; a pulse with nothing queued is an error.
   always @(negedge Clk) begin
      if (hit_pulse || miss_pulse) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_pulse: observed hit=%0b miss=%0b expected none", hit_pulse, miss_pulse);
         end
         if (sb.size() != 0) begin
            logic e;
            e = sb.pop_front();
            check("pulse_kind", {30'd0, hit_pulse, miss_pulse}, {30'd0, e, ~e});
         end
      end
   end

   task automatic run_shot(input logic exp_hit, input logic [1:0] exp_shots, input logic [2:0] exp_end);
      logic [9:0] cx, cy;
      cx = cursor_x;
      cy = cursor_y;
      sb.push_back(exp_hit);
      keycode = KEY;
      step(1);
      check("fire_state", state_dbg, FLASH);
      check("fire_flash", flash_active, 1'b1);
      check("fire_freeze", cursor_freeze, 1'b1);
      check("fire_shots", shots_left, exp_shots);
      keycode = 8'h00;
      cursor_x = 10'd600;
      cursor_y = 10'd400;
      frame();
      check("flash_1tick", state_dbg, FLASH);
      DrawX = duck_x;
      DrawY = duck_y;
      #1;
      check("white_in", flash_white, 1'b1);
      DrawX = duck_x + 10'd17;
      #1;
      check("white_out", flash_white, 1'b0);
      keycode = KEY;
      step(1);
      keycode = 8'h00;
      check("flash_poke_state", state_dbg, FLASH);
      check("flash_poke_shots", shots_left, exp_shots);
      frame();
      check("judge_state", state_dbg, JUDGE);
      check("judge_freeze", cursor_freeze, 1'b1);
      check("judge_flash", flash_active, 1'b0);
      step(1);
      check("cool_state", state_dbg, COOL);
      check("cool_pulse", hit_pulse | miss_pulse, 1'b1);
      cursor_x = cx;
      cursor_y = cy;
      repeat (11) frame();
      check("cool_11", state_dbg, COOL);
      keycode = KEY;
      frame();
      check("cool_exit", state_dbg, exp_end);
      step(3);
      check("held_key_state", state_dbg, exp_end);
      check("held_key_shots", shots_left, exp_shots);
      keycode = 8'h00;
      step(1);
   endtask

   initial begin
      step(2);
      Reset = 1'b0;
      check("rst_state", state_dbg, EMPTY);
      check("rst_shots", shots_left, 2'd0);
      check("rst_flash", flash_active, 1'b0);
      check("rst_freeze", cursor_freeze, 1'b0);
      check("rst_pulses", {hit_pulse, miss_pulse}, 2'b00);

      keycode = KEY;
      step(1);
      keycode = 8'h00;
      step(1);
      check("fire_in_empty", state_dbg, EMPTY);

      round_start = 1'b1;
      step(1);
      round_start = 1'b0;
      check("round_shots", shots_left, 2'd3);
      check("round_state", state_dbg, READY);
      check("round_pulses", {hit_pulse, miss_pulse}, 2'b00);

      cursor_x = 10'd320; cursor_y = 10'd240;
      duck_x = 10'd330; duck_y = 10'd235; duck_alive = 1'b1;
      DrawX = duck_x; DrawY = duck_y;
      #1;
      check("white_ready", flash_white, 1'b0);
      run_shot(1'b1, 2'd2, READY);

      duck_x = 10'd340; duck_y = 10'd240;
      run_shot(1'b0, 2'd1, READY);

      duck_x = 10'd336; duck_y = 10'd256;
      run_shot(1'b1, 2'd0, EMPTY);

      keycode = KEY;
      step(2);
      keycode = 8'h00;
      step(2);
      check("empty_fire_state", state_dbg, EMPTY);
      check("empty_fire_shots", shots_left, 2'd0);

      round_start = 1'b1;
      step(1);
      round_start = 1'b0;
      duck_alive = 1'b0;
      run_shot(1'b0, 2'd2, READY);

      duck_alive = 1'b1;
      cursor_x = 10'd0; cursor_y = 10'd0;
      duck_x = 10'd10; duck_y = 10'd5;
      run_shot(1'b1, 2'd1, READY);

      // round_start mid-flash: back to READY with a full load and no pulse.
      keycode = KEY;
      step(1);
      keycode = 8'h00;
      check("abort_pre_flash", flash_active, 1'b1);
      frame();
      round_start = 1'b1;
      step(1);
      round_start = 1'b0;
      check("abort_state", state_dbg, READY);
      check("abort_shots", shots_left, 2'd3);
      check("abort_flash", flash_active, 1'b0);
      check("abort_freeze", cursor_freeze, 1'b0);
      frame();
      frame();
      check("abort_settled", state_dbg, READY);

      // Reset in cooldown returns every output to its reset value.
      sb.push_back(1'b1);
      keycode = KEY;
      step(1);
      keycode = 8'h00;
      frame();
      frame();
      step(1);
      check("pre_rst_state", state_dbg, COOL);
      frame();
      frame();
      Reset = 1'b1;
      step(1);
      check("mid_rst_state", state_dbg, EMPTY);
      check("mid_rst_shots", shots_left, 2'd0);
      check("mid_rst_flash", flash_active, 1'b0);
      check("mid_rst_freeze", cursor_freeze, 1'b0);
      check("mid_rst_white", flash_white, 1'b0);
      check("mid_rst_pulses", {hit_pulse, miss_pulse}, 2'b00);
      Reset = 1'b0;
      step(2);
      check("post_rst_state", state_dbg, EMPTY);

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
